// File: rtl/bitstream_pkg.sv
// Constants shared by the byte-to-bitstream transmitter and the matching receiver.
package bitstream_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam int unsigned BIT_ORDER_LSB = 0;
  localparam int unsigned BIT_ORDER_MSB = 1;

endpackage

// File: rtl/byte_to_bitstream_if.sv
// Parallel word input handshake plus serial bit output strobes of the transmitter.
interface byte_to_bitstream_if
  import bitstream_pkg::*;
#(
  parameter int unsigned WIDTH = BYTE_W
) ();

  logic [WIDTH-1:0] byte_in;
  logic             byte_in_valid;
  logic             byte_in_ready;
  logic             data_out;
  logic             data_out_valid;
  logic             data_out_last;

  modport master (
    output byte_in,
    output byte_in_valid,
    input  byte_in_ready,
    input  data_out,
    input  data_out_valid,
    input  data_out_last
  );

  modport slave (
    input  byte_in,
    input  byte_in_valid,
    output byte_in_ready,
    output data_out,
    output data_out_valid,
    output data_out_last
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read and occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/byte_to_bitstream.sv
// Serialises queued parallel words into a gap-free bitstream with per-bit valid and last strobes.
module byte_to_bitstream
  import bitstream_pkg::*;
#(
  parameter int unsigned WIDTH      = BYTE_W,
  parameter int unsigned MSB_FIRST  = BIT_ORDER_LSB,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  byte_to_bitstream_if.slave  bus,
  output logic                busy
);

  localparam int unsigned CntW     = $clog2(WIDTH);
  localparam int unsigned CountW   = $clog2(FIFO_DEPTH) + 1;
  localparam bit          MsbFirst = (MSB_FIRST == BIT_ORDER_MSB);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  logic [0:0]        state_q, state_d;
  logic [WIDTH-1:0]  sr_q, sr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ready_q, ready_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [WIDTH-1:0]  fifo_rdata;
  logic [CountW-1:0] fifo_count, count_next;
  logic              shifting;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (bus.byte_in),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign fifo_push = bus.byte_in_valid & ready_q;

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sr_d     = fifo_rdata;
          cnt_d    = '0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == LastBit) begin
          // Reload on the last bit's edge so consecutive words leave no gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            sr_d     = fifo_rdata;
          end else begin
            sr_d    = '0;
            state_d = ST_IDLE;
          end
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          sr_d  = MsbFirst ? (sr_q << 1) : (sr_q >> 1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready reflects post-edge occupancy so a full FIFO is never written.
  assign count_next = fifo_count + CountW'(fifo_push) - CountW'(fifo_pop);
  assign ready_d    = (count_next != CountW'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign shifting           = (state_q == ST_SHIFT);
  assign bus.byte_in_ready  = ready_q;
  assign bus.data_out_valid = shifting;
  assign bus.data_out       = shifting & (MsbFirst ? sr_q[WIDTH-1] : sr_q[0]);
  assign bus.data_out_last  = shifting & (cnt_q == LastBit);
  assign busy               = (fifo_count != '0) | shifting;

endmodule

// File: tb/tb_byte_to_bitstream.sv
// Scoreboard bench: an LSB-first and an MSB-first transmitter, words reassembled and compared.
module tb_byte_to_bitstream;
  import bitstream_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy0, busy1;
  int unsigned cyc = 0;
  int errors = 0;
  int checks = 0;

  byte_to_bitstream_if #(.WIDTH(8)) if0 ();
  byte_to_bitstream_if #(.WIDTH(8)) if1 ();

  byte_to_bitstream #(.WIDTH(8), .MSB_FIRST(BIT_ORDER_LSB), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rst(rst), .bus(if0), .busy(busy0)
  );
  byte_to_bitstream #(.WIDTH(8), .MSB_FIRST(BIT_ORDER_MSB), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .bus(if1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         bitpos   [2];
  logic [7:0] acc      [2];
  int         run_len  [2];
  int         last_run [2];
  logic       prev_v   [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mon(input int d, input logic v, input logic b, input logic l, input logic bz);
    logic [7:0] w;
    int qs;
    if (!rst) begin
      bitpos[d] = 0; run_len[d] = 0; prev_v[d] = 1'b0;
      return;
    end
    qs = (d == 0) ? q0.size() : q1.size();
    if (v) begin
      check_eq($sformatf("last_flag%0d", d), 32'(l), 32'(bitpos[d] == 7));
      if (d == 0) begin
        if (bitpos[0] < 8) acc[0][bitpos[0]] = b;
      end else begin
        acc[1] = {acc[1][6:0], b};
      end
      bitpos[d]++;
      run_len[d]++;
      if (l) begin
        bitpos[d] = 0;
        check_eq($sformatf("q%0d_nonempty", d), 32'(qs != 0), 32'd1);
        if (qs != 0) begin
          w = (d == 0) ? q0.pop_front() : q1.pop_front();
          check_eq($sformatf("word%0d", d), 32'(acc[d]), 32'(w));
        end
      end
    end else begin
      check_eq($sformatf("idle_out%0d", d), 32'({b, l}), 32'd0);
      if (prev_v[d]) begin
        last_run[d] = run_len[d];
        run_len[d]  = 0;
        if (qs == 0) check_eq($sformatf("busy_fall%0d", d), 32'(bz), 32'd0);
      end
    end
    prev_v[d] = v;
  endtask

  always @(negedge clk) begin
    mon(0, if0.data_out_valid, if0.data_out, if0.data_out_last, busy0);
    mon(1, if1.data_out_valid, if1.data_out, if1.data_out_last, busy1);
  end

  // Drive one word and hold it until accepted; expected word is queued at the accepting edge.
  task automatic send(input int d, input logic [7:0] w, output int unsigned acc_cyc);
    int n = 0;
    @(negedge clk);
    if (d == 0) begin
      if0.byte_in = w; if0.byte_in_valid = 1'b1; if1.byte_in_valid = 1'b0;
    end else begin
      if1.byte_in = w; if1.byte_in_valid = 1'b1; if0.byte_in_valid = 1'b0;
    end
    while (((d == 0) ? if0.byte_in_ready : if1.byte_in_ready) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("ready_timeout", 32'(n), 32'd0);
    @(posedge clk);
    if (d == 0) q0.push_back(w); else q1.push_back(w);
    #1 acc_cyc = cyc;
  endtask

  task automatic stop_drive();
    @(negedge clk);
    if0.byte_in_valid = 1'b0;
    if1.byte_in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy0 || busy1) && n < limit);
    check_eq("drain", 32'({busy0, busy1}), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int unsigned t [6];
    int unsigned t1;
    int n;
    int vseen;
    logic [7:0] w6;

    // Reset held with valid asserted: nothing may be written.
    if0.byte_in = 8'h5A; if0.byte_in_valid = 1'b1;
    if1.byte_in = 8'hA5; if1.byte_in_valid = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", 32'({if0.byte_in_ready, if1.byte_in_ready}), 32'd0);
    check_eq("rst_valid", 32'({if0.data_out_valid, if1.data_out_valid}), 32'd0);
    check_eq("rst_data", 32'({if0.data_out, if0.data_out_last, if1.data_out, if1.data_out_last}),
             32'd0);
    check_eq("rst_busy", 32'({busy0, busy1}), 32'd0);
    rst = 1'b1;
    if0.byte_in_valid = 1'b0; if1.byte_in_valid = 1'b0;
    #1 check_eq("ready_pre_edge", 32'(if0.byte_in_ready), 32'd0);
    @(posedge clk);
    #1 check_eq("ready_after_rel", 32'({if0.byte_in_ready, if1.byte_in_ready}), 32'h3);
    check_eq("busy_after_rel", 32'({busy0, busy1}), 32'd0);

    // Single word A5 LSB first, latency k+2.
    send(0, 8'hA5, t[0]);
    @(negedge clk);
    if0.byte_in_valid = 1'b0;
    check_eq("lat_pre", 32'(if0.data_out_valid), 32'd0);
    @(negedge clk);
    check_eq("lat_first", 32'(if0.data_out_valid), 32'd1);
    check_eq("first_bit", 32'(if0.data_out), 32'd1);
    wait_drain(40);
    check_eq("run_a5", 32'(last_run[0]), 32'd8);
    check_eq("q0_empty_a5", 32'(q0.size()), 32'd0);

    // Back-to-back words: one contiguous 24-bit run.
    send(0, 8'h01, t[0]);
    send(0, 8'hFF, t[1]);
    send(0, 8'h80, t[2]);
    stop_drive();
    check_eq("b2b_accept", t[2] - t[0], 32'd2);
    wait_drain(60);
    check_eq("run_b2b", 32'(last_run[0]), 32'd24);
    check_eq("q0_empty_b2b", 32'(q0.size()), 32'd0);

    // FIFO full with valid held: 4 queued + 1 shifting, ready back at first pop.
    for (int i = 0; i < 5; i++) send(0, 8'(8'h10 + i * 8'h11), t[i]);
    check_eq("full_no_stall", t[4] - t[0], 32'd4);
    w6 = 8'hE7;
    @(negedge clk);
    if0.byte_in = w6;
    check_eq("full_ready", 32'(if0.byte_in_ready), 32'd0);
    n = 0;
    while (if0.byte_in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    t1 = cyc;
    check_eq("ready_rise", t1 - t[0], 32'd9);
    @(posedge clk);
    q0.push_back(w6);
    #1;
    stop_drive();
    wait_drain(120);
    check_eq("q0_empty_full", 32'(q0.size()), 32'd0);

    // Random loopback on both bit orders.
    for (int i = 0; i < 24; i++) begin
      send(int'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), t1);
    end
    stop_drive();
    wait_drain(600);
    check_eq("q0_empty_rand", 32'(q0.size()), 32'd0);
    check_eq("q1_empty_rand", 32'(q1.size()), 32'd0);

    // Mid-word reset at bit 3 of 3C with C3 queued.
    send(0, 8'h3C, t[0]);
    send(0, 8'hC3, t[1]);
    stop_drive();
    while (cyc < t[0] + 4) @(negedge clk);
    check_eq("pre_rst_valid", 32'(if0.data_out_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("mid_rst_out",
             32'({if0.data_out_valid, if0.data_out, if0.data_out_last}), 32'd0);
    check_eq("mid_rst_busy", 32'(busy0), 32'd0);
    check_eq("mid_rst_ready", 32'(if0.byte_in_ready), 32'd0);
    q0.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    vseen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if0.data_out_valid || busy0) vseen++;
    end
    check_eq("post_rst_quiet", 32'(vseen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
